uart_rx: RTL

//  Serial receive stage: samples the asynchronous rxd line, recovers 8N1 frames (LSB first)
//  and presents each byte on data_i with a one-cycle rx_valid strobe.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame width and line levels.
// Used by both the receive and transmit stages.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous inputs.
// RESET_VAL sets the value both flops take while reset is asserted.
module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rxd, recovers LSB-first frames and strobes each byte out.
// Default framing is 8N1; defining UART_RX_PARITY_EN switches to 8E1 with parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] data_i,
    output logic                      rx_valid,
    output logic                      frame_err,
    output logic                      parity_err
);

    localparam int unsigned CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_CNT_W = 3;
    localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(UART_DATA_BITS - 1);

    logic                      rxd_s;
    uart_state_e               state_q, state_d;
    logic [CNT_W-1:0]          clk_cnt_q, clk_cnt_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      rx_valid_q, rx_valid_d;
    logic                      frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                      par_bit_q, par_bit_d;
    logic                      parity_err_q, parity_err_d;
`endif

    uart_sync_2ff #(
        .RESET_VAL (UART_IDLE_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    // Frame recovery: next state, bit timing and result pulses.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + CNT_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (rxd_s != UART_IDLE_LEVEL) begin
                    state_d = START;
                end
            end
            START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    state_d = (rxd_s == UART_IDLE_LEVEL) ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rxd_s, shift_q[UART_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt_q == BIT_LAST) begin
                    par_bit_d = rxd_s;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    if (rxd_s == UART_IDLE_LEVEL) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bit_q != even_parity(shift_q)) begin
                            parity_err_d = 1'b1;
                        end else begin
                            data_d     = shift_q;
                            rx_valid_d = 1'b1;
                        end
`else
                        data_d     = shift_q;
                        rx_valid_d = 1'b1;
`endif
                    end else begin
                        // Low stop bit: report once, then wait out any break.
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                clk_cnt_d = '0;
                if (rxd_s == UART_IDLE_LEVEL) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d != state_q) begin
            clk_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_i    = data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
